// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin sharing of the data memory between the core and an
//            external grant/rvalid port, with burst lock and a core stall bound.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int AW       = 30,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_wr,
    input  logic          ext_lock,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

    logic          w_cpu_gnt;
    logic          w_ext_gnt;
    logic          w_cpu_stall;
    logic          r_last;
    logic          r_locked;
    logic [3:0]    r_wait_cnt;
    logic          r_ext_rvalid;
    logic [DW-1:0] r_ext_rdata;

    // Starvation guard outranks the lock so the core stall stays bounded.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ext_gnt = 1'b0;
        if (cpu_req && !ext_req) begin
            w_cpu_gnt = 1'b1;
        end else if (!cpu_req && ext_req) begin
            w_ext_gnt = 1'b1;
        end else if (cpu_req && ext_req) begin
            if (r_wait_cnt == c_MAX_WAIT) begin
                w_cpu_gnt = 1'b1;
            end else if (r_locked) begin
                w_ext_gnt = 1'b1;
            end else if (r_last) begin
                w_cpu_gnt = 1'b1;
            end else begin
                w_ext_gnt = 1'b1;
            end
        end
    end

    assign w_cpu_stall = cpu_req & ~w_cpu_gnt;

    assign mem_wr    = w_ext_gnt ? (ext_wr & ext_req) : (w_cpu_gnt & cpu_wr & cpu_req);
    assign mem_addr  = w_ext_gnt ? ext_addr  : cpu_addr;
    assign mem_wdata = w_ext_gnt ? ext_wdata : cpu_wdata;

    assign cpu_rdata  = mem_rdata;
    assign cpu_stall  = w_cpu_stall;
    assign ext_gnt    = w_ext_gnt;
    assign ext_rvalid = r_ext_rvalid;
    assign ext_rdata  = r_ext_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last       <= 1'b1;
            r_locked     <= 1'b0;
            r_wait_cnt   <= 4'd0;
            r_ext_rvalid <= 1'b0;
            r_ext_rdata  <= '0;
        end else begin
            if (w_cpu_gnt || w_ext_gnt) begin
                r_last <= w_ext_gnt;
            end
            r_locked <= w_ext_gnt & ext_lock & ext_req;
            if (w_cpu_stall) begin
                if (r_wait_cnt != c_MAX_WAIT) begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
            end else begin
                r_wait_cnt <= 4'd0;
            end
            r_ext_rvalid <= w_ext_gnt;
            // Write grants capture the pre-write content as the response.
            if (w_ext_gnt) begin
                r_ext_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire
